// File: rtl/lock_reset_seq_if.sv
// lock_reset_seq_if: groups the lock inputs and the sequenced reset/status
// outputs of lock_reset_seq. The master modport is the sequencer side and the
// slave modport is the side that supplies locks and consumes the resets.
interface lock_reset_seq_if #(
  parameter int NUM_LOCK = 2,
  parameter int NUM_OUT  = 2,
  parameter int CNT_W    = 8
);
  logic [NUM_LOCK-1:0] lock;
  logic [NUM_OUT-1:0]  n_rst_out;
  logic                ready;
  logic [CNT_W-1:0]    loss_cnt;
  logic                pll_rst;

  modport master (input lock, output n_rst_out, ready, loss_cnt, pll_rst);
  modport slave  (output lock, input n_rst_out, ready, loss_cnt, pll_rst);
endinterface

// File: rtl/lock_reset_seq.sv
// lock_reset_seq: PLL-lock qualifier and staged reset sequencer.
// Synchronises and debounces NUM_LOCK raw lock flags, then releases NUM_OUT
// active-low resets in ascending order, STAGGER_CYCLES apart. Any lock loss
// drops every reset on the next edge and bumps a saturating loss counter.
// Optional macro LOCK_TIMEOUT_EN: a lock-acquire timeout that pulses pll_rst.
module lock_reset_seq #(
  parameter int NUM_LOCK       = 2,
  parameter int NUM_OUT        = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 16,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int PLL_RST_CYCLES = 64
) (
  input  logic             clk,
  input  logic             n_rst,
  lock_reset_seq_if.master bus
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int SW = $clog2(STAGGER_CYCLES + 1);
  localparam int IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);

  // Reject illegal parameter combinations at elaboration.
  if (NUM_LOCK < 1 || NUM_OUT < 1 || SYNC_STAGES < 2 || FILTER_CYCLES < 1 ||
      STAGGER_CYCLES < 1 || CNT_W < 1 || TIMEOUT_CYCLES < 1 || PLL_RST_CYCLES < 1) begin : g_param_check
    $error("lock_reset_seq: illegal parameter value");
  end

`ifdef LOCK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(PLL_RST_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PRST_LAST = PW'(PLL_RST_CYCLES - 1);

  typedef enum logic [2:0] {WAIT_LOCK, FILTER, RELEASE, RUN, PLL_RESET} state_t;
`else
  typedef enum logic [1:0] {WAIT_LOCK, FILTER, RELEASE, RUN} state_t;
`endif

  state_t              r_state, w_state_next;
  logic                r_lk;
  logic [NUM_LOCK-1:0] w_sync;
  logic [FW-1:0]       r_filt, w_filt_next;
  logic [SW-1:0]       r_stag, w_stag_next;
  logic [IW-1:0]       r_idx, w_idx_next;
  logic [NUM_OUT-1:0]  r_out, w_out_next;
  logic                r_ready, w_ready_next;
  logic [CNT_W-1:0]    r_loss, w_loss_next;
`ifdef LOCK_TIMEOUT_EN
  logic [TW-1:0]       r_timer, w_timer_next;
  logic [PW-1:0]       r_pcnt, w_pcnt_next;
  logic                r_pll, w_pll_next;
`endif

  // Per-lock flop chain bringing each asynchronous lock flag into clk.
  for (genvar gi = 0; gi < NUM_LOCK; gi++) begin : g_sync
    logic [SYNC_STAGES-1:0] r_sync;
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_sync <= '0;
      else        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.lock[gi]};
    end
    assign w_sync[gi] = r_sync[SYNC_STAGES-1];
  end

  // Registered AND of synchronised locks; keeps lock fully off any output path.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_lk <= 1'b0;
    else        r_lk <= &w_sync;
  end

  // Next-state and registered-output logic; a loss takes priority over release.
  always_comb begin
    w_state_next = r_state;
    w_filt_next  = r_filt;
    w_stag_next  = r_stag;
    w_idx_next   = r_idx;
    w_out_next   = r_out;
    w_ready_next = r_ready;
    w_loss_next  = r_loss;
`ifdef LOCK_TIMEOUT_EN
    w_timer_next = r_timer;
    w_pcnt_next  = r_pcnt;
    w_pll_next   = r_pll;
`endif
    case (r_state)
      WAIT_LOCK: begin
        if (r_lk) begin
          w_state_next = FILTER;
          w_filt_next  = '0;
        end
      end
      FILTER: begin
        if (!r_lk) begin
          w_state_next = WAIT_LOCK;
          w_filt_next  = '0;
        end else if (r_filt == FILT_LAST) begin
          w_state_next = RELEASE;
          w_filt_next  = '0;
          w_idx_next   = '0;
          w_stag_next  = '0;
          w_out_next   = NUM_OUT'(1);
        end else begin
          w_filt_next = r_filt + FW'(1);
        end
      end
      RELEASE, RUN: begin
        if (!r_lk) begin
          w_state_next = WAIT_LOCK;
          w_out_next   = '0;
          w_ready_next = 1'b0;
          w_stag_next  = '0;
          w_idx_next   = '0;
          if (r_loss != {CNT_W{1'b1}}) w_loss_next = r_loss + CNT_W'(1);
        end else if (r_state == RELEASE) begin
          if (r_stag == STAG_LAST) begin
            w_stag_next = '0;
            if (r_idx == IDX_LAST) begin
              w_state_next = RUN;
              w_ready_next = 1'b1;
            end else begin
              // Bits fill from bit 0 upward, so a shift-in of 1 releases the next one.
              w_idx_next = r_idx + IW'(1);
              w_out_next = (r_out << 1) | NUM_OUT'(1);
            end
          end else begin
            w_stag_next = r_stag + SW'(1);
          end
        end
      end
`ifdef LOCK_TIMEOUT_EN
      PLL_RESET: begin
        if (r_pcnt == PRST_LAST) begin
          w_state_next = WAIT_LOCK;
          w_pll_next   = 1'b0;
          w_pcnt_next  = '0;
          w_timer_next = '0;
        end else begin
          w_pcnt_next = r_pcnt + PW'(1);
        end
      end
`endif
      default: w_state_next = WAIT_LOCK;
    endcase
`ifdef LOCK_TIMEOUT_EN
    // Acquire timer: runs only while hunting for lock; expiry overrides a release.
    if (r_state == WAIT_LOCK || r_state == FILTER) begin
      if (r_timer == TO_LAST) begin
        w_state_next = PLL_RESET;
        w_pll_next   = 1'b1;
        w_pcnt_next  = '0;
        w_timer_next = '0;
        w_filt_next  = '0;
        w_out_next   = '0;
        w_idx_next   = '0;
        w_stag_next  = '0;
      end else if (w_state_next == RELEASE) begin
        w_timer_next = '0;
      end else begin
        w_timer_next = r_timer + TW'(1);
      end
    end
`endif
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= WAIT_LOCK;
      r_filt  <= '0;
      r_stag  <= '0;
      r_idx   <= '0;
      r_out   <= '0;
      r_ready <= 1'b0;
      r_loss  <= '0;
`ifdef LOCK_TIMEOUT_EN
      r_timer <= '0;
      r_pcnt  <= '0;
      r_pll   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_filt  <= w_filt_next;
      r_stag  <= w_stag_next;
      r_idx   <= w_idx_next;
      r_out   <= w_out_next;
      r_ready <= w_ready_next;
      r_loss  <= w_loss_next;
`ifdef LOCK_TIMEOUT_EN
      r_timer <= w_timer_next;
      r_pcnt  <= w_pcnt_next;
      r_pll   <= w_pll_next;
`endif
    end
  end

  assign bus.n_rst_out = r_out;
  assign bus.ready     = r_ready;
  assign bus.loss_cnt  = r_loss;
`ifdef LOCK_TIMEOUT_EN
  assign bus.pll_rst   = r_pll;
`else
  assign bus.pll_rst   = 1'b0;
`endif

endmodule
